// File: rtl/merge_service_pkg.sv
// Shared types for the server-stream merge: FSM states and the round-robin pick helper.
package merge_service_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } merge_state_e;

  // On a tie the requester that did not finish the last packet wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
    logic [1:0] gnt;
    case (req)
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = req;
    endcase
    return gnt;
  endfunction

endpackage

// File: rtl/merge_service_if.sv
// Packet stream bundle (data/valid/ready/sop/eop/empty); svr = sink side, clt = source side.
interface merge_service_if #(
  parameter int DATA_BITS  = 512,
  parameter int EMPTY_BITS = 6
);
  logic [DATA_BITS-1:0]  data;
  logic                  valid;
  logic                  ready;
  logic                  sop;
  logic                  eop;
  logic [EMPTY_BITS-1:0] empty;

  modport svr (input data, valid, sop, eop, empty, output ready);
  modport clt (output data, valid, sop, eop, empty, input ready);
endinterface

// File: rtl/merge_service_rr_arb2.sv
// Two-request round-robin arbiter: combinational grant, last-winner state updated on a strobe.
module merge_service_rr_arb2
  import merge_service_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic       upd_idx_i,
  output logic [1:0] gnt_o
);

  logic last_q;

  // Remember which requester completed the most recent packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (upd_i) begin
      last_q <= upd_idx_i;
    end
  end

  assign gnt_o = rr_pick(req_i, last_q);

endmodule

// File: rtl/merge_service.sv
// Packet-atomic 2:1 round-robin merge with a single registered output stage and packet counters.
module merge_service
  import merge_service_pkg::*;
#(
  parameter int DATA_BITS  = 512,
  parameter int EMPTY_BITS = 6
) (
  input  logic         Clk,
  input  logic         Rst_n,
  output logic [31:0]  stats_in_pkt0,
  output logic [31:0]  stats_in_pkt1,
  output logic [31:0]  stats_out_pkt,
  merge_service_if.svr in0,
  merge_service_if.svr in1,
  merge_service_if.clt out
);

  merge_state_e          state_q, state_d;
  logic [1:0]            arb_gnt_s, gnt_s;
  logic                  gate_s, rdy0_s, rdy1_s, acc0_s, acc1_s, upd_s;
  logic                  valid_q, sop_q, eop_q;
  logic [DATA_BITS-1:0]  data_q;
  logic [EMPTY_BITS-1:0] empty_q;
  logic [31:0]           stats_in0_q, stats_in1_q, stats_out_q;

  merge_service_rr_arb2 u_arb (
    .clk       (Clk),
    .rst_n     (Rst_n),
    .req_i     ({in1.valid, in0.valid}),
    .upd_i     (upd_s),
    .upd_idx_i (acc1_s),
    .gnt_o     (arb_gnt_s)
  );

  // A lock overrides the arbiter until the owning input's eop is taken.
  always_comb begin
    gnt_s = 2'b00;
    case (state_q)
      IDLE:    gnt_s = arb_gnt_s;
      LOCK0:   gnt_s = 2'b01;
      LOCK1:   gnt_s = 2'b10;
      default: gnt_s = 2'b00;
    endcase
  end

  assign gate_s    = !valid_q || out.ready;
  assign rdy0_s    = Rst_n && gnt_s[0] && gate_s;
  assign rdy1_s    = Rst_n && gnt_s[1] && gate_s;
  assign in0.ready = rdy0_s;
  assign in1.ready = rdy1_s;
  assign acc0_s    = in0.valid && rdy0_s;
  assign acc1_s    = in1.valid && rdy1_s;
  assign upd_s     = (acc0_s && in0.eop) || (acc1_s && in1.eop);

  // Next-state: any accepted non-eop beat locks; the owner's eop unlocks.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (acc0_s && !in0.eop) begin
          state_d = LOCK0;
        end else if (acc1_s && !in1.eop) begin
          state_d = LOCK1;
        end else begin
          state_d = IDLE;
        end
      end
      LOCK0: begin
        if (acc0_s && in0.eop) state_d = IDLE;
        else                   state_d = LOCK0;
      end
      LOCK1: begin
        if (acc1_s && in1.eop) state_d = IDLE;
        else                   state_d = LOCK1;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Output stage: load on accept, drop valid once the sink takes it.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      empty_q <= '0;
    end else if (acc0_s) begin
      valid_q <= 1'b1;
      data_q  <= in0.data;
      sop_q   <= in0.sop;
      eop_q   <= in0.eop;
      empty_q <= in0.empty;
    end else if (acc1_s) begin
      valid_q <= 1'b1;
      data_q  <= in1.data;
      sop_q   <= in1.sop;
      eop_q   <= in1.eop;
      empty_q <= in1.empty;
    end else if (out.ready) begin
      valid_q <= 1'b0;
    end
  end

  // Packet counters, wrapping modulo 2^32.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stats_in0_q <= 32'd0;
      stats_in1_q <= 32'd0;
      stats_out_q <= 32'd0;
    end else begin
      if (acc0_s && in0.eop)               stats_in0_q <= stats_in0_q + 32'd1;
      if (acc1_s && in1.eop)               stats_in1_q <= stats_in1_q + 32'd1;
      if (valid_q && out.ready && eop_q)   stats_out_q <= stats_out_q + 32'd1;
    end
  end

  assign out.valid     = valid_q;
  assign out.data      = data_q;
  assign out.sop       = sop_q;
  assign out.eop       = eop_q;
  assign out.empty     = empty_q;
  assign stats_in_pkt0 = stats_in0_q;
  assign stats_in_pkt1 = stats_in1_q;
  assign stats_out_pkt = stats_out_q;

endmodule

// File: tb/tb_merge_service.sv
// Bench for merge_service: directed scenarios plus a randomized run against a packet scoreboard.
module tb_merge_service;
  import merge_service_pkg::*;

  typedef struct packed {
    logic [511:0] d;
    logic         sop;
    logic         eop;
    logic [5:0]   empty;
  } beat_t;

  logic        clk   = 1'b0;
  logic        Rst_n = 1'b0;
  logic [31:0] st_in0, st_in1, st_out;

  always #5 clk = ~clk;

  merge_service_if in0_if ();
  merge_service_if in1_if ();
  merge_service_if out_if ();

  merge_service dut (
    .Clk           (clk),
    .Rst_n         (Rst_n),
    .stats_in_pkt0 (st_in0),
    .stats_in_pkt1 (st_in1),
    .stats_out_pkt (st_out),
    .in0           (in0_if),
    .in1           (in1_if),
    .out           (out_if)
  );

  // packets waiting to be offered (tx) and accepted beats awaiting output (ex)
  beat_t        tx0[$], tx1[$], ex0[$], ex1[$];
  int           hist[$];
  logic         rdy0_hist[$];
  int unsigned  n_chk = 0, n_fail = 0;
  logic [31:0]  m_in0 = 0, m_in1 = 0, m_out = 0;
  logic [31:0]  seq = 0;
  logic         pend0 = 0, pend1 = 0, cur_open = 0, cur_src = 0;
  logic         hold = 0, stall_en = 0, oready = 1, any_rdy1 = 0;
  logic [511:0] hold_data = '0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mk_pkt(input int src, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      for (int w = 0; w < 16; w++) b.d[w*32 +: 32] = $urandom;
      b.d[8]     = src[0];
      b.d[15:9]  = i[6:0];
      b.d[47:16] = seq;
      b.sop      = (i == 0);
      b.eop      = (i == len - 1);
      b.empty    = b.eop ? 6'($urandom_range(0, 63)) : 6'd0;
      if (src == 0) tx0.push_back(b);
      else          tx1.push_back(b);
    end
    seq++;
  endtask

  task automatic drive();
    beat_t b;
    if (!pend0) in0_if.valid = (tx0.size() > 0) && !(stall_en && ($urandom_range(0, 3) == 0));
    if (!pend1) in1_if.valid = (tx1.size() > 0) && !(stall_en && ($urandom_range(0, 3) == 0));
    if (in0_if.valid) begin
      b = tx0[0];
      in0_if.data = b.d; in0_if.sop = b.sop; in0_if.eop = b.eop; in0_if.empty = b.empty;
    end
    if (in1_if.valid) begin
      b = tx1[0];
      in1_if.data = b.d; in1_if.sop = b.sop; in1_if.eop = b.eop; in1_if.empty = b.empty;
    end
    out_if.ready = stall_en ? ($urandom_range(0, 3) != 0) : oready;
  endtask

  task automatic observe();
    beat_t b;
    int    code;
    int    ex_sz;
    logic  src;
    code = 0;
    check("ready_onehot", in0_if.ready & in1_if.ready, 1'b0);
    if (in1_if.ready) any_rdy1 = 1'b1;
    if (hold) begin
      check("hold_valid", out_if.valid, 1'b1);
      check("hold_data", out_if.data, hold_data);
    end
    hold = out_if.valid && !out_if.ready;
    if (hold) begin
      hold_data = out_if.data;
      check("bp_readies", {in1_if.ready, in0_if.ready}, 2'b00);
    end
    if (out_if.valid && out_if.ready) begin
      src   = out_if.data[8];
      code  = src ? 2 : 1;
      ex_sz = src ? ex1.size() : ex0.size();
      if (cur_open) check("atomic_src", src, cur_src);
      check("beat_queued", (ex_sz != 0), 1'b1);
      if (ex_sz != 0) begin
        if (src) b = ex1.pop_front();
        else     b = ex0.pop_front();
        check("out_data", out_if.data, b.d);
        check("out_ctl", {out_if.sop, out_if.eop, out_if.empty}, {b.sop, b.eop, b.empty});
      end
      cur_open = !out_if.eop;
      cur_src  = src;
      if (out_if.eop) m_out++;
    end
    hist.push_back(code);
    rdy0_hist.push_back(in0_if.ready);
    if (in0_if.valid && in0_if.ready) begin
      b = tx0.pop_front(); ex0.push_back(b);
      if (b.eop) m_in0++;
    end
    if (in1_if.valid && in1_if.ready) begin
      b = tx1.pop_front(); ex1.push_back(b);
      if (b.eop) m_in1++;
    end
    pend0 = in0_if.valid && !in0_if.ready;
    pend1 = in1_if.valid && !in1_if.ready;
  endtask

  task automatic cycle();
    drive();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_if.valid, 1'b0);
    check("rst_out_data", out_if.data, 512'd0);
    check("rst_out_ctl", {out_if.sop, out_if.eop, out_if.empty}, 8'd0);
    check("rst_stats", {st_in0, st_in1, st_out}, 96'd0);
    check("rst_state", dut.state_q, IDLE);
    check("rst_readies", {in1_if.ready, in0_if.ready}, 2'b00);
    tx0.delete(); tx1.delete(); ex0.delete(); ex1.delete();
    hist.delete(); rdy0_hist.delete();
    pend0 = 0; pend1 = 0; cur_open = 0; hold = 0; any_rdy1 = 0;
    m_in0 = 0; m_in1 = 0; m_out = 0;
    in0_if.valid = 1'b0; in1_if.valid = 1'b0; oready = 1'b1; stall_en = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    Rst_n = 1'b1;
  endtask

  task automatic drain();
    int budget;
    budget = 300;
    while ((tx0.size() + tx1.size() + ex0.size() + ex1.size()) != 0 && budget > 0) begin
      budget--;
      cycle();
    end
    cycle();
    check("drain_done", tx0.size() + tx1.size() + ex0.size() + ex1.size(), 0);
  endtask

  task automatic chk_stats();
    check("stats_in0", st_in0, m_in0);
    check("stats_in1", st_in1, m_in1);
    check("stats_out", st_out, m_out);
  endtask

  initial begin
    in0_if.valid = 0; in0_if.data = '0; in0_if.sop = 0; in0_if.eop = 0; in0_if.empty = '0;
    in1_if.valid = 0; in1_if.data = '0; in1_if.sop = 0; in1_if.eop = 0; in1_if.empty = '0;
    out_if.ready = 1'b1;

    // single 3-beat packet on in0: one-cycle latency, in1 never sees ready
    do_reset();
    mk_pkt(0, 3);
    repeat (5) cycle();
    check("t1_hist0", hist[0], 0);
    check("t1_hist1", hist[1], 1);
    check("t1_hist2", hist[2], 1);
    check("t1_hist3", hist[3], 1);
    check("t1_hist4", hist[4], 0);
    check("t1_in1_ready", any_rdy1, 1'b0);
    check("t1_in0_cnt", st_in0, 32'd1);
    check("t1_out_cnt", st_out, 32'd1);
    chk_stats();

    // tie from reset: in0 first, in1 follows without a bubble
    do_reset();
    mk_pkt(0, 2);
    mk_pkt(1, 2);
    repeat (6) cycle();
    check("t2_hist0", hist[0], 0);
    check("t2_hist1", hist[1], 1);
    check("t2_hist2", hist[2], 1);
    check("t2_hist3", hist[3], 2);
    check("t2_hist4", hist[4], 2);
    check("t2_both", {st_in0, st_in1}, {32'd1, 32'd1});
    chk_stats();

    // in1 locked mid-packet: in0 waits until in1's eop
    do_reset();
    mk_pkt(1, 4);
    cycle();
    rdy0_hist.delete();
    mk_pkt(0, 2);
    repeat (4) cycle();
    check("t3_rdy0_a", rdy0_hist[0], 1'b0);
    check("t3_rdy0_b", rdy0_hist[1], 1'b0);
    check("t3_rdy0_c", rdy0_hist[2], 1'b0);
    check("t3_rdy0_d", rdy0_hist[3], 1'b1);
    drain();
    chk_stats();

    // back-to-back single-beat packets on both: strict alternation
    do_reset();
    for (int i = 0; i < 60; i++) begin
      mk_pkt(0, 1);
      mk_pkt(1, 1);
    end
    repeat (100) cycle();
    check("t4_in0_50", st_in0, 32'd50);
    check("t4_in1_50", st_in1, 32'd50);
    check("t4_out_99_100", (st_out == 32'd99) || (st_out == 32'd100), 1'b1);
    check("t4_hist0", hist[0], 0);
    for (int i = 1; i < 100; i++) check("t4_alternate", hist[i], (i % 2 == 1) ? 1 : 2);
    chk_stats();

    // 5-cycle output stall mid-packet
    do_reset();
    mk_pkt(0, 4);
    mk_pkt(1, 2);
    repeat (2) cycle();
    oready = 1'b0;
    repeat (5) cycle();
    oready = 1'b1;
    drain();
    check("t5_counts", {st_in0, st_in1, st_out}, {32'd1, 32'd1, 32'd2});
    chk_stats();

    // reset during beat 2 of a 4-beat packet, then a tie goes to in0
    do_reset();
    mk_pkt(0, 4);
    repeat (2) cycle();
    do_reset();
    mk_pkt(0, 1);
    mk_pkt(1, 1);
    repeat (3) cycle();
    check("t6_first_in0", hist[1], 1);
    check("t6_then_in1", hist[2], 2);
    chk_stats();

    // counters wrap from all-ones to zero
    force dut.stats_in0_q = 32'hFFFF_FFFF;
    force dut.stats_out_q = 32'hFFFF_FFFF;
    #1;
    release dut.stats_in0_q;
    release dut.stats_out_q;
    m_in0 = 32'hFFFF_FFFF;
    m_out = 32'hFFFF_FFFF;
    mk_pkt(0, 1);
    drain();
    check("t7_in0_wrap", st_in0, 32'd0);
    check("t7_out_wrap", st_out, 32'd0);
    chk_stats();

    // randomized traffic with input stalls and output backpressure
    do_reset();
    stall_en = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (tx0.size() < 6 && $urandom_range(0, 2) == 0) mk_pkt(0, $urandom_range(1, 4));
      if (tx1.size() < 6 && $urandom_range(0, 2) == 0) mk_pkt(1, $urandom_range(1, 4));
      cycle();
    end
    stall_en = 1'b0;
    oready = 1'b1;
    drain();
    chk_stats();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
